// File: rtl/axi_mem_mon_pkg.sv
// Shared types and the beat-address helper for the AXI write-channel monitor.
// The entry structs are sized by the default bus widths used throughout the testbed.
package axi_mem_mon_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int ID_W   = 10;
  localparam int TS_W   = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } aw_entry_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [TS_W-1:0]   ts;
  } w_entry_t;

  // WRAP assumes a legal AXI wrap length (2/4/8/16 beats), so the modulo is a mask.
  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [ADDR_W-1:0] start,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst,
    input logic [7:0]        n
  );
    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_len;
    logic [ADDR_W-1:0] base;
    bytes    = ADDR_ONE << size;
    step     = ADDR_W'(n) << size;
    wrap_len = ADDR_W'({1'b0, len} + 9'd1) << size;
    base     = start & ~(wrap_len - ADDR_ONE);
    case (burst)
      BURST_FIXED: beat_addr = start;
      BURST_WRAP:  beat_addr = base + ((start + step) & (wrap_len - ADDR_ONE));
      default:     beat_addr = (n == 8'd0) ? start : (start & ~(bytes - ADDR_ONE)) + step;
    endcase
  endfunction

endpackage

// File: rtl/mon_fifo.sv
// Small synchronous FIFO with async active-high reset; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_mem_write_monitor.sv
// Passive AXI AW/W observer: pairs each W beat with its burst and streams one
// commit record per beat (id, beat address, data, strb, last, timestamp).
module axi_mem_write_monitor
  import axi_mem_mon_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = ADDR_W,
  parameter int AXI_DATA_WIDTH = DATA_W,
  parameter int AXI_ID_WIDTH   = ID_W,
  parameter int AW_DEPTH       = 8,
  parameter int W_DEPTH        = 16,
  parameter int TS_WIDTH       = TS_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        aw_valid_i,
  input  logic                        aw_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic                        w_valid_i,
  input  logic                        w_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  output logic                        rec_valid_o,
  input  logic                        rec_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     rec_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   rec_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   rec_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] rec_strb_o,
  output logic                        rec_last_o,
  output logic [TS_WIDTH-1:0]         rec_ts_o,
  output logic                        err_overflow_o,
  output logic                        err_last_o
);

  localparam int AW_BITS = $bits(aw_entry_t);
  localparam int W_BITS  = $bits(w_entry_t);
  localparam logic [TS_WIDTH-1:0] TS_ONE = 1;

  logic [TS_WIDTH-1:0] ts_q;
  logic [7:0]          beat_q;
  logic                err_overflow_q;
  logic                err_last_q;

  aw_entry_t          aw_in;
  aw_entry_t          aw_head;
  w_entry_t           w_in;
  w_entry_t           w_head;
  logic [AW_BITS-1:0] aw_head_bits;
  logic [W_BITS-1:0]  w_head_bits;

  logic aw_push, aw_pop, aw_full, aw_empty;
  logic w_push, w_pop, w_full, w_empty;
  logic pair_valid, fire, at_last, overflow;

  assign aw_push = aw_valid_i & aw_ready_i;
  assign w_push  = w_valid_i & w_ready_i;
  assign aw_in   = '{id: aw_id_i, addr: aw_addr_i, len: aw_len_i, size: aw_size_i, burst: aw_burst_i};
  assign w_in    = '{data: w_data_i, strb: w_strb_i, last: w_last_i, ts: ts_q};
  assign aw_head = aw_entry_t'(aw_head_bits);
  assign w_head  = w_entry_t'(w_head_bits);

  mon_fifo #(.WIDTH(AW_BITS), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk_i), .rst(rst_i), .push(aw_push), .push_data(aw_in), .pop(aw_pop),
    .pop_data(aw_head_bits), .full(aw_full), .empty(aw_empty)
  );

  mon_fifo #(.WIDTH(W_BITS), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk_i), .rst(rst_i), .push(w_push), .push_data(w_in), .pop(w_pop),
    .pop_data(w_head_bits), .full(w_full), .empty(w_empty)
  );

  // Burst progress is tracked by the counter; w_last is only cross-checked.
  assign pair_valid = ~aw_empty & ~w_empty;
  assign fire       = pair_valid & rec_ready_i;
  assign at_last    = (beat_q == aw_head.len);
  assign w_pop      = fire;
  assign aw_pop     = fire & at_last;
  assign overflow   = (aw_push & aw_full & ~aw_pop) | (w_push & w_full & ~w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q           <= '0;
      beat_q         <= '0;
      err_overflow_q <= 1'b0;
      err_last_q     <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_ONE;
      if (fire) beat_q <= at_last ? 8'd0 : beat_q + 8'd1;
      if (overflow) err_overflow_q <= 1'b1;
      if (fire && (w_head.last != at_last)) err_last_q <= 1'b1;
    end
  end

  // Record fields read as zero whenever no pair is available.
  assign rec_valid_o    = pair_valid;
  assign rec_id_o       = pair_valid ? aw_head.id : '0;
  assign rec_addr_o     = pair_valid ? beat_addr(aw_head.addr, aw_head.len, aw_head.size,
                                                 aw_head.burst, beat_q) : '0;
  assign rec_data_o     = pair_valid ? w_head.data : '0;
  assign rec_strb_o     = pair_valid ? w_head.strb : '0;
  assign rec_last_o     = pair_valid & w_head.last;
  assign rec_ts_o       = pair_valid ? w_head.ts : '0;
  assign err_overflow_o = err_overflow_q;
  assign err_last_o     = err_last_q;

endmodule

// File: tb/tb_axi_mem_write_monitor.sv
// Scoreboard bench for axi_mem_write_monitor: directed AW/W traffic pushes expected
// records; an independent monitor pops and compares each accepted record.
module tb_axi_mem_write_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_valid, aw_ready;
  logic [9:0]  aw_id;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        rec_valid_o, rec_ready_i;
  logic [9:0]  rec_id_o;
  logic [63:0] rec_addr_o, rec_data_o;
  logic [7:0]  rec_strb_o;
  logic        rec_last_o;
  logic [31:0] rec_ts_o;
  logic        err_overflow_o, err_last_o;

  typedef struct {
    logic [9:0]  id;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [31:0] ts;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc;
  logic [31:0] ts;
  logic [31:0] ts_a [2];
  logic [63:0] t1_addr [4] = '{64'h1000, 64'h1008, 64'h1010, 64'h1018};
  logic [63:0] t2_addr [4] = '{64'h1018, 64'h1000, 64'h1008, 64'h1010};

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  axi_mem_write_monitor dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst),
    .w_valid_i(w_valid), .w_ready_i(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
    .w_last_i(w_last),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_id_o(rec_id_o),
    .rec_addr_o(rec_addr_o), .rec_data_o(rec_data_o), .rec_strb_o(rec_strb_o),
    .rec_last_o(rec_last_o), .rec_ts_o(rec_ts_o),
    .err_overflow_o(err_overflow_o), .err_last_o(err_last_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle of traffic; the handshake happens on the following rising edge.
  task automatic applyStimulus(
    input logic aw_v, input logic [9:0] id, input logic [63:0] addr, input logic [7:0] len,
    input logic [2:0] size, input logic [1:0] burst,
    input logic w_v, input logic [63:0] data, input logic [7:0] strb, input logic last,
    output logic [31:0] ts_out
  );
    @(negedge clk);
    aw_valid = aw_v; aw_ready = aw_v;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    w_valid = w_v; w_ready = w_v;
    w_data = data; w_strb = strb; w_last = last;
    ts_out = cyc;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                        output logic [31:0] ts_out);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1, data, strb, last, ts_out);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      aw_valid = 1'b0; aw_ready = 1'b0; w_valid = 1'b0; w_ready = 1'b0;
    end
  endtask

  task automatic expect_rec(input logic [9:0] id, input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic last, input logic [31:0] t);
    rec_t r;
    r.id = id; r.addr = addr; r.data = data; r.strb = strb; r.last = last; r.ts = t;
    exp_q.push_back(r);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    checkOutput({name, "_idle_valid"}, 64'(rec_valid_o), 64'd0);
  endtask

  // Monitor: every accepted record must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rec_valid_o && rec_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_record: got addr=%h data=%h, expected no record",
                   rec_addr_o, rec_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (rec_id_o !== mon_e.id || rec_addr_o !== mon_e.addr || rec_data_o !== mon_e.data ||
              rec_strb_o !== mon_e.strb || rec_last_o !== mon_e.last || rec_ts_o !== mon_e.ts) begin
            failures++;
            $display("[TB] FAIL record: got id=%h addr=%h data=%h strb=%h last=%b ts=%0d, expected id=%h addr=%h data=%h strb=%h last=%b ts=%0d",
                     rec_id_o, rec_addr_o, rec_data_o, rec_strb_o, rec_last_o, rec_ts_o,
                     mon_e.id, mon_e.addr, mon_e.data, mon_e.strb, mon_e.last, mon_e.ts);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rec_ready_i = 1'b0;
    aw_valid = 0; aw_ready = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_ready = 0; w_data = 0; w_strb = 0; w_last = 0;
    #12;
    checkOutput("reset_valid", 64'(rec_valid_o), 64'd0);
    checkOutput("reset_addr", rec_addr_o, 64'd0);
    checkOutput("reset_data", rec_data_o, 64'd0);
    checkOutput("reset_ts", 64'(rec_ts_o), 64'd0);
    checkOutput("reset_err_overflow", 64'(err_overflow_o), 64'd0);
    checkOutput("reset_err_last", 64'(err_last_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rec_ready_i = 1'b1;

    // INCR burst, preceded by an AW valid without ready that must be ignored
    @(negedge clk);
    aw_valid = 1'b1; aw_ready = 1'b0; aw_id = 10'h3FF; aw_addr = 64'hDEAD_0000;
    applyStimulus(1'b1, 10'd1, 64'h1000, 8'd3, 3'd3, 2'd1, 1'b0, '0, '0, 1'b0, ts);
    for (int i = 0; i < 4; i++) begin
      send_w(64'h1111_0000 + 64'(i), 8'hFF, i == 3, ts);
      expect_rec(10'd1, t1_addr[i], 64'h1111_0000 + 64'(i), 8'hFF, i == 3, ts);
    end
    idle(1);
    wait_drain("incr");

    // WRAP burst, AW and first beat in the same cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 0, 10'd2, 64'h1018, 8'd3, 3'd3, 2'd2, 1'b1,
                    64'h2222_0000 + 64'(i), 8'h0F, i == 3, ts);
      expect_rec(10'd2, t2_addr[i], 64'h2222_0000 + 64'(i), 8'h0F, i == 3, ts);
    end
    idle(1);
    wait_drain("wrap");

    // W beats arrive before their AW
    send_w(64'h3333_0000, 8'h0F, 1'b0, ts_a[0]);
    send_w(64'h3333_0001, 8'hF0, 1'b1, ts_a[1]);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checkOutput("w_before_aw_no_record", 64'(rec_valid_o), 64'd0);
    end
    applyStimulus(1'b1, 10'd3, 64'h40, 8'd1, 3'd2, 2'd1, 1'b0, '0, '0, 1'b0, ts);
    expect_rec(10'd3, 64'h40, 64'h3333_0000, 8'h0F, 1'b0, ts_a[0]);
    expect_rec(10'd3, 64'h44, 64'h3333_0001, 8'hF0, 1'b1, ts_a[1]);
    idle(1);
    wait_drain("w_before_aw");

    // Back-pressure: 17 beats into a 16-deep W buffer
    rec_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i == 0, 10'd4, 64'h2000, 8'd15, 3'd3, 2'd1, 1'b1,
                    64'hB000 + 64'(i), 8'hFF, i == 15, ts);
      expect_rec(10'd4, 64'h2000 + 64'(8 * i), 64'hB000 + 64'(i), 8'hFF, i == 15, ts);
    end
    idle(1);
    checkOutput("full_no_overflow", 64'(err_overflow_o), 64'd0);
    checkOutput("stall_valid", 64'(rec_valid_o), 64'd1);
    send_w(64'hB0FF, 8'hFF, 1'b0, ts);
    idle(1);
    checkOutput("overflow_set", 64'(err_overflow_o), 64'd1);
    checkOutput("stall_addr_stable", rec_addr_o, 64'h2000);
    checkOutput("stall_data_stable", rec_data_o, 64'hB000);
    rec_ready_i = 1'b1;
    wait_drain("overflow");

    // w_last on beat 0 of a two-beat burst, then a probe burst behind it
    checkOutput("err_last_clear", 64'(err_last_o), 64'd0);
    applyStimulus(1'b1, 10'd5, 64'h3000, 8'd1, 3'd3, 2'd1, 1'b1, 64'h5550, 8'hFF, 1'b1, ts);
    expect_rec(10'd5, 64'h3000, 64'h5550, 8'hFF, 1'b1, ts);
    send_w(64'h5551, 8'hFF, 1'b1, ts);
    expect_rec(10'd5, 64'h3008, 64'h5551, 8'hFF, 1'b1, ts);
    applyStimulus(1'b1, 10'd7, 64'h5000, 8'd0, 3'd3, 2'd1, 1'b1, 64'h7770, 8'h3C, 1'b1, ts);
    expect_rec(10'd7, 64'h5000, 64'h7770, 8'h3C, 1'b1, ts);
    idle(1);
    wait_drain("last_mismatch");
    checkOutput("err_last_set", 64'(err_last_o), 64'd1);
    checkOutput("overflow_sticky", 64'(err_overflow_o), 64'd1);

    // Asynchronous reset between clock edges with a record pending
    rec_ready_i = 1'b0;
    applyStimulus(1'b1, 10'd6, 64'h80, 8'd2, 3'd3, 2'd0, 1'b1, 64'h6660, 8'hFF, 1'b0, ts);
    idle(1);
    checkOutput("pre_reset_valid", 64'(rec_valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_valid", 64'(rec_valid_o), 64'd0);
    checkOutput("async_reset_addr", rec_addr_o, 64'd0);
    checkOutput("async_reset_err_overflow", 64'(err_overflow_o), 64'd0);
    checkOutput("async_reset_err_last", 64'(err_last_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rec_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i == 0, 10'd6, 64'h80, 8'd2, 3'd3, 2'd0, 1'b1,
                    64'h8880 + 64'(i), 8'hFF, i == 2, ts);
      expect_rec(10'd6, 64'h80, 64'h8880 + 64'(i), 8'hFF, i == 2, ts);
    end
    idle(1);
    wait_drain("fixed_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_mem_write_monitor.md
Name: axi_mem_write_monitor

Overview:
- Passive observer on the AXI write channels (AW, W) between a test master and the AXI memory model.
- Pairs each accepted W beat with its AW burst and computes the byte address of that beat.
- Emits one commit record per beat (id, beat address, data, strb, last, capture timestamp) on a valid/ready stream.
- Scoreboards consume the stream to learn when and where each write landed. Never drives AXI ready signals.

Parameters:
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width; power of two, >= 8.
- AXI_ID_WIDTH, 10, ID width.
- AW_DEPTH, 8, buffered AW bursts awaiting data; power of two.
- W_DEPTH, 16, buffered W beats awaiting pairing or consumer; power of two.
- TS_WIDTH, 32, timestamp counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- aw_valid_i  in  1  observed AW valid
- aw_ready_i  in  1  observed AW ready
- aw_id_i  in  AXI_ID_WIDTH  observed AW id
- aw_addr_i  in  AXI_ADDR_WIDTH  observed AW start address
- aw_len_i  in  8  observed AW burst length minus one
- aw_size_i  in  3  observed AW beat size, log2 bytes
- aw_burst_i  in  2  observed AW burst type
- w_valid_i  in  1  observed W valid
- w_ready_i  in  1  observed W ready
- w_data_i  in  AXI_DATA_WIDTH  observed W data
- w_strb_i  in  AXI_DATA_WIDTH/8  observed W strobe
- w_last_i  in  1  observed W last
- rec_valid_o  out  1  commit record valid
- rec_ready_i  in  1  consumer ready
- rec_id_o  out  AXI_ID_WIDTH  burst id
- rec_addr_o  out  AXI_ADDR_WIDTH  byte address of this beat
- rec_data_o  out  AXI_DATA_WIDTH  beat data
- rec_strb_o  out  AXI_DATA_WIDTH/8  beat strobe
- rec_last_o  out  1  final beat of burst
- rec_ts_o  out  TS_WIDTH  cycle count at W handshake
- err_overflow_o  out  1  sticky: AW or W buffer overflowed
- err_last_o  out  1  sticky: w_last mismatched the beat count

Behaviour:
- Reset (async, active-high): all FIFOs empty, beat counter 0, timestamp 0. rec_valid_o=0, all rec_*_o=0, both err flags 0.
- Timestamp: free-running counter, +1 every cycle, wraps modulo 2^TS_WIDTH.
- AW capture: on aw_valid_i&aw_ready_i, push {id, addr, len, size, burst} into the AW FIFO.
- W capture: on w_valid_i&w_ready_i, push {data, strb, last, ts} into the W FIFO. ts is the counter value in the handshake cycle.
- W before AW is legal: beats wait in the W FIFO until their AW arrives.
- Overflow: a push into a full FIFO is dropped and sets err_overflow_o. The flag stays set until reset.
- Pairing, combinational from the FIFO heads:
  - rec_valid_o = AW FIFO non-empty & W FIFO non-empty.
  - All rec_*_o come from the heads plus the current beat address.
  - rec_valid_o and rec_* stay stable while rec_ready_i=0.
- On rec_valid_o&rec_ready_i:
  - Pop the W FIFO; beat counter +1.
  - If beat counter == len: pop the AW FIFO, counter := 0.
  - If w_last disagrees with (counter == len): set err_last_o. Popping still follows the counter.
- Beat address, with n = beat counter, s = size, A = start address:
  - FIXED (0): A for every beat.
  - INCR (1): beat 0 = A; beat n>0 = (A aligned down to 2^s) + n*2^s, modulo 2^AXI_ADDR_WIDTH.
  - WRAP (2): wrap size W = (len+1)<<s, base B = A aligned down to W. Beat n = B + ((A + n*2^s) mod W).
  - Reserved (3): treated as INCR.
- Simultaneous events: push and pop on the same FIFO in one cycle is legal, including when full; occupancy is unchanged and no overflow.
- Latency: a beat whose AW is already buffered appears on rec_* the cycle after its W handshake.
- Captures ignore rec_ready_i entirely.
- Reset mid-burst: all buffered state is discarded immediately.

Decomposition:
- Shared package axi_mem_mon_pkg:
  - burst-type constants BURST_FIXED/INCR/WRAP.
  - aw_entry_t and w_entry_t struct typedefs.
  - function beat_addr(start, len, size, burst, n).
- One sub-module, mon_fifo: parametric width/depth, async active-high reset, push/pop/full/empty, same-cycle push+pop when full. Instantiated twice.

Test Plan:
- INCR single burst: AW addr 0x1000, len 3, size 3, then 4 W beats, rec_ready_i=1 -> records at 0x1000, 0x1008, 0x1010, 0x1018; last only on the 4th; ts strictly increasing.
- WRAP burst: addr 0x1018, len 3, size 3 -> addresses 0x1018, 0x1000, 0x1008, 0x1010.
- W before AW: 2 W beats, then 5 cycles later AW addr 0x40, len 1, size 2, INCR -> no record before the AW handshake; then 0x40, 0x44 with the original W timestamps.
- Back-pressure/overflow: rec_ready_i=0, push 17 W beats with W_DEPTH=16 -> err_overflow_o=1 after the 17th; the first 16 beats are delivered in order once rec_ready_i=1.
- Last mismatch: AW len 1, w_last on beat 0 -> err_last_o=1; both beats are still emitted and the AW is popped after beat 1.
- Async reset asserted mid-burst, between clock edges -> rec_valid_o=0 immediately; after release a new FIXED burst at addr 0x80, len 2 gives 0x80 three times.
